// File: rtl/spi_master_pkg.sv
// spi_master_pkg: shared types for the byte-oriented SPI initiator.
// FSM states, SPI mode bundle and default chip-select gap.
package spi_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        WAIT,
        HOLD,
        GAP
    } state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    localparam int CS_GAP_DEF = 2;

endpackage

// File: rtl/spi_master_clkgen.sv
// spi_master_clkgen: half-period counter and sck generator.
// hp_end fires at terminal count; lead/trail mark sck edges in SHIFT.
module spi_master_clkgen
    import spi_master_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_i,
    input  logic             toggle_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             cpol_i,
    output logic             hp_end_o,
    output logic             lead_edge_o,
    output logic             trail_edge_o,
    output logic             sck_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic             sck_q, sck_d;

    // Equality compare wraps at div_i, so all-ones never overflows
    assign hp_end_o     = run_i & (cnt_q == div_i);
    assign lead_edge_o  = hp_end_o & toggle_i & ~phase_q;
    assign trail_edge_o = hp_end_o & toggle_i & phase_q;
    assign sck_o        = sck_q;

    // Next count, sck phase and registered sck level
    always_comb begin
        cnt_d   = cnt_q + DIV_W'(1);
        phase_d = phase_q;
        if (!run_i) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (hp_end_o) begin
            cnt_d = '0;
            if (toggle_i) begin
                phase_d = ~phase_q;
            end
        end
        sck_d = cpol_i ^ phase_d;
    end

    // Counter and sck state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
            sck_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            sck_q   <= sck_d;
        end
    end

endmodule

// File: rtl/spi_master_byte.sv
// spi_master_byte: byte-stream SPI initiator, mode 0, MSB first.
// Define SPI_MASTER_MODE_EN to add runtime cpol/cpha inputs.
module spi_master_byte
    import spi_master_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16,
    parameter int CS_GAP = CS_GAP_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef SPI_MASTER_MODE_EN
    input  logic              cpol,
    input  logic              cpha,
`endif
    input  logic [DIV_W-1:0]  div,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_last,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              sck,
    output logic              ss_n,
    output logic              mosi,
    input  logic              miso
);

    localparam int HP_W = $clog2(2 * DATA_W + CS_GAP + 1);
    localparam logic [HP_W-1:0] HP_LAST  = HP_W'(2 * DATA_W - 1);
    localparam logic [HP_W-1:0] GAP_LAST = HP_W'(CS_GAP - 1);

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              last_q, last_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic [HP_W-1:0]   hp_q, hp_d;
    logic              mosi_q, mosi_d;
    logic              ss_n_q, ss_n_d;
    logic              rx_valid_q, rx_valid_d;
    spi_mode_t         mode_in, mode_q, mode_d;

    logic run, toggle, hp_end, lead_edge, trail_edge;
    logic ready, byte_end, sample_edge, shift_edge;

`ifdef SPI_MASTER_MODE_EN
    assign mode_in = {cpol, cpha};
`else
    assign mode_in = '0;
`endif

    assign run = (state_q == SETUP) || (state_q == SHIFT) ||
                 (state_q == HOLD)  || (state_q == GAP);
    assign toggle   = (state_q == SHIFT);
    assign byte_end = toggle & hp_end & (hp_q == HP_LAST);

    // cpha=1 skips the first leading edge: the MSB is already on mosi
    assign sample_edge = mode_q.cpha ? trail_edge : lead_edge;
    assign shift_edge  = mode_q.cpha ?
                         (lead_edge & (hp_q != '0)) :
                         (trail_edge & (hp_q != HP_LAST));

    spi_master_clkgen #(
        .DIV_W(DIV_W)
    ) u_clkgen (
        .clk         (clk),
        .rst_n       (rst_n),
        .run_i       (run),
        .toggle_i    (toggle),
        .div_i       (div_q),
        .cpol_i      (mode_q.cpol),
        .hp_end_o    (hp_end),
        .lead_edge_o (lead_edge),
        .trail_edge_o(trail_edge),
        .sck_o       (sck)
    );

    assign tx_ready = ready & rst_n;
    assign busy     = (state_q != IDLE);
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign ss_n     = ss_n_q;
    assign mosi     = mosi_q;

    // Transaction sequencing, shifting and handshake
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        last_d     = last_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        hp_d       = hp_q;
        mosi_d     = mosi_q;
        ss_n_d     = ss_n_q;
        rx_valid_d = 1'b0;
        mode_d     = mode_q;
        ready      = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready  = 1'b1;
                mode_d = mode_in;
                if (tx_valid) begin
                    div_d   = div;
                    last_d  = tx_last;
                    tx_sh_d = tx_data;
                    mosi_d  = tx_data[DATA_W-1];
                    ss_n_d  = 1'b0;
                    hp_d    = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (hp_end) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (hp_end) begin
                    hp_d = hp_q + HP_W'(1);
                    if (sample_edge) begin
                        rx_sh_d = {rx_sh_q[DATA_W-2:0], miso};
                    end
                    if (shift_edge) begin
                        tx_sh_d = tx_sh_q << 1;
                        mosi_d  = tx_sh_q[DATA_W-2];
                    end
                    if (byte_end) begin
                        hp_d       = '0;
                        rx_valid_d = 1'b1;
                        rx_data_d  = rx_sh_d;
                        if (last_q) begin
                            state_d = HOLD;
                        end else begin
                            ready = 1'b1;
                            if (tx_valid) begin
                                last_d  = tx_last;
                                tx_sh_d = tx_data;
                                mosi_d  = tx_data[DATA_W-1];
                            end else begin
                                state_d = WAIT;
                            end
                        end
                    end
                end
            end
            WAIT: begin
                ready = 1'b1;
                if (tx_valid) begin
                    last_d  = tx_last;
                    tx_sh_d = tx_data;
                    mosi_d  = tx_data[DATA_W-1];
                    hp_d    = '0;
                    state_d = SHIFT;
                end
            end
            HOLD: begin
                if (hp_end) begin
                    ss_n_d  = 1'b1;
                    hp_d    = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (hp_end) begin
                    hp_d = hp_q + HP_W'(1);
                    if (hp_q == GAP_LAST) begin
                        hp_d    = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            div_q      <= '0;
            last_q     <= 1'b0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            hp_q       <= '0;
            mosi_q     <= 1'b0;
            ss_n_q     <= 1'b1;
            rx_valid_q <= 1'b0;
            mode_q     <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            last_q     <= last_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            hp_q       <= hp_d;
            mosi_q     <= mosi_d;
            ss_n_q     <= ss_n_d;
            rx_valid_q <= rx_valid_d;
            mode_q     <= mode_d;
        end
    end

endmodule

// File: tb/tb_spi_master_byte.sv
// tb_spi_master_byte: directed bench for the SPI initiator.
// Loopback vectors, back-to-back, WAIT, slave memory and reset cases.
module tb_spi_master_byte;

    logic        clk;
    logic        rst_n;
    logic [15:0] div;
    logic [7:0]  tx_data;
    logic        tx_last;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        busy;
    logic        sck;
    logic        ss_n;
    logic        mosi;
    logic        miso;
    logic        use_slave;
    logic        slave_miso;
`ifdef SPI_MASTER_MODE_EN
    logic        cpol;
    logic        cpha;
`endif

    spi_master_byte dut (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef SPI_MASTER_MODE_EN
        .cpol    (cpol),
        .cpha    (cpha),
`endif
        .div     (div),
        .tx_data (tx_data),
        .tx_last (tx_last),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .busy    (busy),
        .sck     (sck),
        .ss_n    (ss_n),
        .mosi    (mosi),
        .miso    (miso)
    );

    assign miso = use_slave ? slave_miso : mosi;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Bus monitor: cumulative counters, sampled on the falling clk edge
    int       n_rise = 0;
    int       n_ssf  = 0;
    int       n_low  = 0;
    int       n_gap  = 0;
    int       n_rx   = 0;
    logic [7:0] rx_log [64];
    logic     sck_p  = 1'b0;
    logic     ss_p   = 1'b1;

    always @(negedge clk) begin
        if (sck && !sck_p) n_rise <= n_rise + 1;
        if (!ss_n && ss_p) n_ssf <= n_ssf + 1;
        if (!ss_n) n_low <= n_low + 1;
        if (ss_n && busy) n_gap <= n_gap + 1;
        if (rx_valid) begin
            rx_log[n_rx % 64] <= rx_data;
            n_rx <= n_rx + 1;
        end
        sck_p <= sck;
        ss_p  <= ss_n;
    end

    // SPI slave memory model, mode 0: cmd 02 write / 03 read, addr, data
    logic [7:0] mem [256];
    logic [7:0] s_sh, s_cmd, s_addr, s_out, o_sh;
    int         s_bits = 0;
    logic [7:0] s_nxt;
    assign s_nxt = {s_sh[6:0], mosi};

    always @(posedge sck or posedge ss_n) begin
        if (ss_n) begin
            s_bits <= 0;
        end else begin
            s_sh   <= s_nxt;
            s_bits <= s_bits + 1;
            if (s_bits == 7) s_cmd <= s_nxt;
            if (s_bits == 15) begin
                s_addr <= s_nxt;
                s_out  <= mem[s_nxt];
            end
            if (s_bits == 23 && s_cmd == 8'h02) mem[s_addr] <= s_nxt;
        end
    end

    always @(negedge sck or posedge ss_n) begin
        if (ss_n) begin
            slave_miso <= 1'b0;
        end else if (s_bits == 16) begin
            slave_miso <= s_out[7];
            o_sh       <= {s_out[6:0], 1'b0};
        end else if (s_bits > 16) begin
            slave_miso <= o_sh[7];
            o_sh       <= {o_sh[6:0], 1'b0};
        end else begin
            slave_miso <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offer one byte and return at the falling edge after acceptance
    task automatic send_byte(input logic [7:0] d, input logic l);
        int n = 0;
        tx_data  = d;
        tx_last  = l;
        tx_valid = 1'b1;
        #1;
        while (!tx_ready && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("send_ready", {31'd0, tx_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0] dv;
        logic [7:0]  data;
        int          low;
        int          gap;
    } vec_t;

    vec_t vecs [5];
    int   b_rise, b_ssf, b_low, b_gap, b_rx, n;

    initial begin
        vecs[0] = '{16'd0, 8'hA5, 18, 2};
        vecs[1] = '{16'd1, 8'h00, 36, 4};
        vecs[2] = '{16'd2, 8'hFF, 54, 6};
        vecs[3] = '{16'd0, 8'h81, 18, 2};
        vecs[4] = '{16'd3, 8'h5A, 72, 8};

        rst_n     = 1'b0;
        div       = '0;
        tx_data   = '0;
        tx_last   = 1'b0;
        tx_valid  = 1'b0;
        use_slave = 1'b0;
`ifdef SPI_MASTER_MODE_EN
        cpol = 1'b0;
        cpha = 1'b0;
`endif
        repeat (2) @(negedge clk);
        #1;
        check("rst_ss_n", {31'd0, ss_n}, 32'd1);
        check("rst_sck", {31'd0, sck}, 32'd0);
        check("rst_mosi", {31'd0, mosi}, 32'd0);
        check("rst_tx_ready", {31'd0, tx_ready}, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_tx_ready", {31'd0, tx_ready}, 32'd1);
        @(negedge clk);

        // Single-byte loopback transactions; div is changed after accept
        for (int i = 0; i < 5; i++) begin
            b_rise = n_rise;
            b_low  = n_low;
            b_gap  = n_gap;
            b_rx   = n_rx;
            div = vecs[i].dv;
            send_byte(vecs[i].data, 1'b1);
            div      = ~vecs[i].dv;
            tx_valid = 1'b0;
            wait_idle();
            check("vec_rx_count", n_rx - b_rx, 1);
            check("vec_rx_data", {24'd0, rx_log[b_rx % 64]},
                  {24'd0, vecs[i].data});
            check("vec_rises", n_rise - b_rise, 8);
            check("vec_ss_low", n_low - b_low, vecs[i].low);
            check("vec_gap", n_gap - b_gap, vecs[i].gap);
        end

        // Back-to-back bytes with tx_valid held, div=3
        b_rise = n_rise;
        b_ssf  = n_ssf;
        b_low  = n_low;
        b_rx   = n_rx;
        div = 16'd3;
        send_byte(8'h3C, 1'b0);
        send_byte(8'hC3, 1'b1);
        tx_valid = 1'b0;
        wait_idle();
        check("b2b_ss_falls", n_ssf - b_ssf, 1);
        check("b2b_rises", n_rise - b_rise, 16);
        check("b2b_ss_low", n_low - b_low, 136);
        check("b2b_rx_count", n_rx - b_rx, 2);
        check("b2b_rx0", {24'd0, rx_log[b_rx % 64]}, 32'h3C);
        check("b2b_rx1", {24'd0, rx_log[(b_rx + 1) % 64]}, 32'hC3);

        // Stall between bytes: WAIT keeps ss_n low and sck idle
        b_rise = n_rise;
        b_ssf  = n_ssf;
        b_rx   = n_rx;
        div = 16'd0;
        send_byte(8'h11, 1'b0);
        tx_valid = 1'b0;
        n = 0;
        while (n_rx == b_rx && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        repeat (25) @(negedge clk);
        #1;
        check("wait_sck", {31'd0, sck}, 32'd0);
        check("wait_ss_n", {31'd0, ss_n}, 32'd0);
        check("wait_ready", {31'd0, tx_ready}, 32'd1);
        check("wait_busy", {31'd0, busy}, 32'd1);
        repeat (25) @(negedge clk);
        send_byte(8'h22, 1'b1);
        tx_valid = 1'b0;
        wait_idle();
        check("wait_rx_count", n_rx - b_rx, 2);
        check("wait_rx0", {24'd0, rx_log[b_rx % 64]}, 32'h11);
        check("wait_rx1", {24'd0, rx_log[(b_rx + 1) % 64]}, 32'h22);
        check("wait_ss_falls", n_ssf - b_ssf, 1);
        check("wait_rises", n_rise - b_rise, 16);

        // Slave memory: write C7 to 0x40, then read it back
        use_slave = 1'b1;
        div = 16'd1;
        send_byte(8'h02, 1'b0);
        send_byte(8'h40, 1'b0);
        send_byte(8'hC7, 1'b1);
        tx_valid = 1'b0;
        wait_idle();
        b_rx = n_rx;
        send_byte(8'h03, 1'b0);
        send_byte(8'h40, 1'b0);
        send_byte(8'h00, 1'b1);
        tx_valid = 1'b0;
        wait_idle();
        check("mem_rx_count", n_rx - b_rx, 3);
        check("mem_readback", {24'd0, rx_log[(b_rx + 2) % 64]}, 32'hC7);
        use_slave = 1'b0;

        // Reset during the 4th bit aborts cleanly
        b_rise = n_rise;
        b_rx   = n_rx;
        div = 16'd1;
        send_byte(8'hFF, 1'b1);
        tx_valid = 1'b0;
        n = 0;
        while (n_rise < b_rise + 4 && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("abort_reached", n_rise - b_rise, 4);
        check("abort_mosi_pre", {31'd0, mosi}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_sck", {31'd0, sck}, 32'd0);
        check("abort_ss_n", {31'd0, ss_n}, 32'd1);
        check("abort_mosi", {31'd0, mosi}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        repeat (4) @(negedge clk);
        check("abort_no_rx", n_rx - b_rx, 0);
        rst_n = 1'b1;
        @(negedge clk);
        b_rx = n_rx;
        div = 16'd0;
        send_byte(8'h5A, 1'b1);
        tx_valid = 1'b0;
        wait_idle();
        check("post_rst_count", n_rx - b_rx, 1);
        check("post_rst_rx", {24'd0, rx_log[b_rx % 64]}, 32'h5A);

`ifdef SPI_MASTER_MODE_EN
        // Mode 3 loopback: sck idles high, sampling on rising edges
        cpol = 1'b1;
        cpha = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("m3_idle_pre", {31'd0, sck}, 32'd1);
        b_rise = n_rise;
        b_low  = n_low;
        b_rx   = n_rx;
        div = 16'd0;
        send_byte(8'h96, 1'b1);
        tx_valid = 1'b0;
        wait_idle();
        check("m3_rx", {24'd0, rx_log[b_rx % 64]}, 32'h96);
        check("m3_rises", n_rise - b_rise, 8);
        check("m3_ss_low", n_low - b_low, 18);
        check("m3_idle_post", {31'd0, sck}, 32'd1);
        cpol = 1'b0;
        cpha = 1'b0;
        repeat (3) @(negedge clk);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
